// File: rtl/frame_packer_if.sv
`default_nettype none
// ============================================================================
//  Module   : frame_packer_if
//  Purpose  : Pixel-in / word-out handshake bundle for frame_packer.
//             The slave modport is the packer's view. The master modport is
//             the surrounding logic's view: it supplies pixels and the
//             downstream ready, and it observes the output word stream.
//  Signals  : valid_i, unpacked_i, ready_o      - pixel input handshake
//             valid_o, packed_o, ready_i        - word output handshake
//             frame_done_o                      - last-word-of-frame pulse
//  Revision : 1.0 - initial release
// ============================================================================
interface frame_packer_if #(
  parameter int unpacked_width_p = 1,
  parameter int packed_num_p     = 8
);
  localparam int WORD_W = unpacked_width_p * packed_num_p;

  logic                        valid_i;
  logic [unpacked_width_p-1:0] unpacked_i;
  logic                        ready_o;
  logic                        valid_o;
  logic [WORD_W-1:0]           packed_o;
  logic                        ready_i;
  logic                        frame_done_o;

  modport slave (
    input  valid_i, unpacked_i, ready_i,
    output ready_o, valid_o, packed_o, frame_done_o
  );

  modport master (
    output valid_i, unpacked_i, ready_i,
    input  ready_o, valid_o, packed_o, frame_done_o
  );
endinterface
`default_nettype wire

// File: rtl/frame_packer.sv
`default_nettype none
// ============================================================================
//  Module   : frame_packer
//  Purpose  : Packs a narrow pixel stream into UART-sized words. Every frame
//             starts with sync_len_p sync words. The final word of each line
//             is zero-padded, so every line starts at slot 0 of a new word.
//  Ports    : clk_i        - clock
//             reset_i      - synchronous active-high reset
//             bus (slave)  - pixel input handshake (valid_i/unpacked_i/ready_o),
//                            word output handshake (valid_o/packed_o/ready_i),
//                            frame_done_o pulse on the load of a frame's last word
//  Revision : 1.0 - initial release
// ============================================================================
module frame_packer #(
  parameter int linewidth_px_p   = 161,
  parameter int lines_p          = 120,
  parameter int unpacked_width_p = 1,
  parameter int packed_num_p     = 8,
  parameter int sync_len_p       = 2,
  parameter logic [unpacked_width_p*packed_num_p-1:0] sync_word_p =
    (unpacked_width_p*packed_num_p)'(8'hA5)
) (
  input wire            clk_i,
  input wire            reset_i,
  frame_packer_if.slave bus
);

  localparam int UW     = unpacked_width_p;
  localparam int WORD_W = unpacked_width_p * packed_num_p;

  // Each counter is sized for its largest value (terminal count), minimum 1 bit.
  localparam int SLOT_W = (packed_num_p   > 1) ? $clog2(packed_num_p)   : 1;
  localparam int PX_W   = (linewidth_px_p > 1) ? $clog2(linewidth_px_p) : 1;
  localparam int LINE_W = (lines_p        > 1) ? $clog2(lines_p)        : 1;
  localparam int SYNC_W = (sync_len_p     > 1) ? $clog2(sync_len_p)     : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(packed_num_p - 1);
  localparam logic [PX_W-1:0]   PX_LAST   = PX_W'(linewidth_px_p - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(lines_p - 1);
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(sync_len_p - 1);

  localparam logic [0:0] ST_SYNC = 1'b0;
  localparam logic [0:0] ST_PACK = 1'b1;

  logic [0:0]        state;
  logic [SYNC_W-1:0] sync_cnt;
  logic [SLOT_W-1:0] slot_cnt;
  logic [PX_W-1:0]   px_cnt;
  logic [LINE_W-1:0] line_cnt;
  logic [WORD_W-1:0] acc;
  logic              out_valid;
  logic [WORD_W-1:0] out_word;
  logic              done_pulse;

  logic              reg_free;
  logic              accept;
  logic              slot_last;
  logic              line_last;
  logic              frame_last;
  logic [WORD_W-1:0] merged;

  // The output register can take a new word when it is empty or is being
  // drained in this same cycle.
  assign reg_free   = ~out_valid | bus.ready_i;
  assign bus.ready_o = (state == ST_PACK) & reg_free;
  assign accept     = bus.valid_i & bus.ready_o;

  assign slot_last  = (slot_cnt == SLOT_LAST);
  assign line_last  = (px_cnt == PX_LAST);
  assign frame_last = line_last & (line_cnt == LINE_LAST);

  // Accumulator with the incoming pixel dropped into its slot. Slots not yet
  // written stay zero, which provides the end-of-line padding for free.
  always_comb begin
    merged = acc;
    for (int k = 0; k < packed_num_p; k++) begin
      if (slot_cnt == SLOT_W'(k)) begin
        merged[k*UW +: UW] = bus.unpacked_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= ST_SYNC;
      sync_cnt   <= '0;
      slot_cnt   <= '0;
      px_cnt     <= '0;
      line_cnt   <= '0;
      acc        <= '0;
      out_valid  <= 1'b0;
      out_word   <= '0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      // Default: a drained word leaves the register empty; any load below
      // overrides this, so a same-cycle drain and load keeps valid high.
      if (bus.ready_i) begin
        out_valid <= 1'b0;
      end

      case (state)
        ST_SYNC: begin
          if (reg_free) begin
            out_word  <= sync_word_p;
            out_valid <= 1'b1;
            if (sync_cnt == SYNC_LAST) begin
              sync_cnt <= '0;
              state    <= ST_PACK;
            end else begin
              sync_cnt <= sync_cnt + SYNC_W'(1);
            end
          end
        end

        ST_PACK: begin
          if (accept) begin
            // A word closes on a full accumulator or on the last pixel of a line.
            if (slot_last || line_last) begin
              out_word  <= merged;
              out_valid <= 1'b1;
              acc       <= '0;
              slot_cnt  <= '0;
            end else begin
              acc      <= merged;
              slot_cnt <= slot_cnt + SLOT_W'(1);
            end

            if (line_last) begin
              px_cnt <= '0;
              if (frame_last) begin
                line_cnt   <= '0;
                done_pulse <= 1'b1;
                state      <= ST_SYNC;
              end else begin
                line_cnt <= line_cnt + LINE_W'(1);
              end
            end else begin
              px_cnt <= px_cnt + PX_W'(1);
            end
          end
        end

        default: state <= ST_SYNC;
      endcase
    end
  end

  assign bus.valid_o      = out_valid;
  assign bus.packed_o     = out_word;
  assign bus.frame_done_o = done_pulse;

endmodule
`default_nettype wire
